and_gate_stim_checker: RTL and testbench

Synthesizable self-checking driver for the 2-input AND gate DUT. It sits on the other side of the DUT's A/B/Y interface. On a start request it walks A/B through all four input combinations in order 00, 01, 10, 11, where A is the MSB. For each vector it samples Y, compares it against the expected A&B, and reports pass/fail counts plus per-vector error pulses. It replaces bench-only concurrent assertions with hardware that can also run on silicon or an FPGA.

---
 rtl/and_chk_pkg.sv | 16 +
 rtl/and_gate_stim_checker_sat_counter.sv | 39 +++
 rtl/and_gate_stim_checker.sv | 179 +++++++++++++++++
 tb/tb_and_gate_stim_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/and_chk_pkg.sv
// Shared types and constants for the AND-gate stimulus checker.
//   chk_state_t : sweep FSM state encoding
//   NUM_VECTORS : number of input combinations in one sweep
//   VEC_W       : width of the {A,B} vector index
package and_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_W       = 2;

endpackage : and_chk_pkg

// File: rtl/and_gate_stim_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count up by one, holding at all-ones
//   q        : registered count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sat_counter

// File: rtl/and_gate_stim_checker.sv
// Self-checking stimulus driver for a 2-input AND gate.
// On start, walks {A,B} through 00,01,10,11, holds each vector HOLD_CYCLES
// cycles, samples Y at the end of the hold and compares it against A&B.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle sweep request, ignored unless idle
//   a_o, b_o  : registered drives to the gate inputs
//   y_i       : gate output
//   busy      : sweep in progress
//   done      : one-cycle pulse at sweep end
//   pass_cnt  : saturating count of matching vectors
//   fail_cnt  : saturating count of mismatching vectors
//   err_pulse : one-cycle pulse per mismatch
//   err_vec   : {A,B} of the most recent mismatch
module and_gate_stim_checker
    import and_chk_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_pulse,
    output logic [1:0]       err_vec
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VECTORS - 1);

    chk_state_t        state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_vec_q, err_vec_d;

    logic              start_acc_c;
    logic              sample_c;
    logic              mismatch_c;
    logic [VEC_W-1:0]  vec_inc_c;

    // Decode of the current cycle: accepted start, sample edge, and mismatch.
    // X/Z on y_i deliberately counts as a mismatch.
    always_comb begin
        start_acc_c = (state_q == IDLE) && start;
        sample_c    = (state_q == DRIVE) && (hold_q == HOLD_LAST);
        mismatch_c  = sample_c && (y_i !== (a_q & b_q));
        vec_inc_c   = vec_q + VEC_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        hold_d      = hold_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_pulse_d = 1'b0;
        err_vec_d   = err_vec_q;

        case (state_q)
            IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start_acc_c) begin
                    state_d   = DRIVE;
                    vec_d     = '0;
                    hold_d    = '0;
                    busy_d    = 1'b1;
                    err_vec_d = 2'b00;
                end
            end

            DRIVE: begin
                hold_d = hold_q + HOLD_W'(1);
                if (sample_c) begin
                    hold_d = '0;
                    if (mismatch_c) begin
                        err_pulse_d = 1'b1;
                        err_vec_d   = {a_q, b_q};
                    end
                    if (vec_q == VEC_LAST) begin
                        // Sweep complete: park the gate inputs low.
                        state_d = DONE;
                        vec_d   = '0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d = vec_inc_c;
                        a_d   = vec_inc_c[1];
                        b_d   = vec_inc_c[0];
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                vec_d   = '0;
                hold_d  = '0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            hold_q      <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_vec_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            hold_q      <= hold_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_pulse_q <= err_pulse_d;
            err_vec_q   <= err_vec_d;
        end
    end

    // Result counters, cleared by an accepted start.
    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc_c),
        .inc (sample_c && !mismatch_c),
        .q   (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc_c),
        .inc (mismatch_c),
        .q   (fail_cnt)
    );

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_pulse = err_pulse_q;
    assign err_vec   = err_vec_q;

endmodule : and_gate_stim_checker

// File: tb/tb_and_gate_stim_checker.sv
// Directed bench for and_gate_stim_checker: three instances cover
// HOLD_CYCLES=1/CNT_W=8 (with selectable gate faults), HOLD_CYCLES=3, and CNT_W=2.
module tb_and_gate_stim_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance 1: HOLD_CYCLES=1, CNT_W=8, gate model chosen by mode
    logic       start1 = 1'b0;
    logic       a1, b1, y1, busy1, done1, ep1;
    logic [7:0] pc1, fc1;
    logic [1:0] ev1;
    int         mode = 0;   // 0 healthy, 1 stuck-at-0, 2 OR gate
    assign y1 = (mode == 0) ? (a1 & b1) : (mode == 1) ? 1'b0 : (a1 | b1);

    and_gate_stim_checker #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
        .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .y_i(y1),
        .busy(busy1), .done(done1), .pass_cnt(pc1), .fail_cnt(fc1),
        .err_pulse(ep1), .err_vec(ev1));

    // Instance 2: HOLD_CYCLES=3, healthy gate
    logic       start3 = 1'b0;
    logic       a3, b3, busy3, done3, ep3;
    logic [7:0] pc3, fc3;
    logic [1:0] ev3;

    and_gate_stim_checker #(.HOLD_CYCLES(3), .CNT_W(8)) u_h3 (
        .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3), .y_i(a3 & b3),
        .busy(busy3), .done(done3), .pass_cnt(pc3), .fail_cnt(fc3),
        .err_pulse(ep3), .err_vec(ev3));

    // Instance 3: CNT_W=2, healthy gate
    logic       startw = 1'b0;
    logic       aw, bw, busyw, donew, epw;
    logic [1:0] pcw, fcw;
    logic [1:0] evw;

    and_gate_stim_checker #(.HOLD_CYCLES(1), .CNT_W(2)) u_w2 (
        .clk(clk), .rst(rst), .start(startw), .a_o(aw), .b_o(bw), .y_i(aw & bw),
        .busy(busyw), .done(donew), .pass_cnt(pcw), .fail_cnt(fcw),
        .err_pulse(epw), .err_vec(evw));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep on instance 1 with the current gate mode.
    task automatic sweep_h1(input string nm, input int exp_pass, input int exp_fail,
                            input int exp_errs, input logic [1:0] exp_ev_mid,
                            input logic [1:0] exp_ev_end);
        int errs;
        errs = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_val({nm, " busy after start"}, 32'(busy1), 32'd1);
        check_val({nm, " vec0"}, 32'({a1, b1}), 32'd0);
        check_val({nm, " cnt cleared"}, 32'({pc1, fc1}), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            errs += int'(ep1);
            check_val({nm, " vec"}, 32'({a1, b1}), 32'(i));
            if (i == 2) check_val({nm, " err_vec mid"}, 32'(ev1), 32'(exp_ev_mid));
        end
        step();
        errs += int'(ep1);
        check_val({nm, " done"}, 32'({done1, busy1}), 32'b10);
        check_val({nm, " ab at done"}, 32'({a1, b1}), 32'd0);
        check_val({nm, " pass_cnt"}, 32'(pc1), 32'(exp_pass));
        check_val({nm, " fail_cnt"}, 32'(fc1), 32'(exp_fail));
        check_val({nm, " err_vec end"}, 32'(ev1), 32'(exp_ev_end));
        // start while in DONE must be dropped
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_val({nm, " start in DONE ignored"}, 32'({done1, busy1}), 32'b00);
        check_val({nm, " err pulses"}, 32'(errs), 32'(exp_errs));
        check_val({nm, " cnt hold"}, 32'({pc1, fc1}), 32'({8'(exp_pass), 8'(exp_fail)}));
    endtask

    initial begin
        int cyc;
        int dones;

        // Reset values
        #2;
        check_val("rst h1 outs", 32'({a1, b1, busy1, done1, ep1, ev1, pc1, fc1}), 32'd0);
        check_val("rst h3 outs", 32'({a3, b3, busy3, done3, ep3, ev3, pc3, fc3}), 32'd0);
        check_val("rst w2 outs", 32'({aw, bw, busyw, donew, epw, evw, pcw, fcw}), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Healthy, stuck-at-0, OR fault, back to back
        mode = 0;
        sweep_h1("healthy", 4, 0, 0, 2'b00, 2'b00);
        mode = 1;
        sweep_h1("stuck0", 3, 1, 1, 2'b00, 2'b11);
        mode = 2;
        sweep_h1("or_fault", 2, 2, 2, 2'b01, 2'b10);

        // HOLD_CYCLES=3 with a spurious start mid-sweep
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        check_val("h3 vec at 0", 32'({busy3, a3, b3}), 32'b100);
        cyc = 0;
        while (!done3 && cyc < 40) begin
            step();
            cyc++;
            start3 = (cyc == 5);
            if (cyc == 2)  check_val("h3 hold 00", 32'({a3, b3}), 32'd0);
            if (cyc == 3)  check_val("h3 vec 01", 32'({a3, b3}), 32'd1);
            if (cyc == 6)  check_val("h3 vec 10", 32'({a3, b3}), 32'd2);
            if (cyc == 11) check_val("h3 vec 11", 32'({a3, b3}), 32'd3);
        end
        start3 = 1'b0;
        check_val("h3 done latency", 32'(cyc), 32'd12);
        check_val("h3 pass_cnt", 32'({pc3, fc3}), 32'({8'd4, 8'd0}));
        step();
        check_val("h3 idle after done", 32'({busy3, done3}), 32'd0);

        // CNT_W=2 saturation
        startw = 1'b1;
        step();
        startw = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("w2 done", 32'(donew), 32'd1);
        check_val("w2 pass sat", 32'(pcw), 32'd3);
        check_val("w2 fail", 32'(fcw), 32'd0);
        step();

        // Asynchronous reset during vector 10
        mode = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        step();
        check_val("pre-rst vec 10", 32'({a1, b1}), 32'd2);
        check_val("pre-rst pass", 32'(pc1), 32'd2);
        rst = 1'b1;
        #1;
        check_val("async rst outs", 32'({a1, b1, busy1, pc1, fc1}), 32'd0);
        step();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            dones += int'(done1) + int'(busy1);
        end
        check_val("no done/resume after rst", 32'(dones), 32'd0);
        sweep_h1("post_rst", 4, 0, 0, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_and_gate_stim_checker
